cla_seq_ctrl: RTL and testbench

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

---
 rtl/cla_seq_pkg.sv | 21 ++
 rtl/cla4_slice.sv | 43 ++++
 rtl/cla_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_cla_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_pkg
// Purpose  : Shared types and constants for the nibble-serial CLA adder
//            controller (state enum, slice width).
// Revision : 1.0 - initial release
// ============================================================================
package cla_seq_pkg;

   // Width of one carry-lookahead slice; operands are processed in chunks of this.
   localparam int NIB_W = 4;

   // Controller states; IDLE must encode as zero so reset lands there.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : cla_seq_pkg
`default_nettype wire

// File: rtl/cla4_slice.sv
`default_nettype none
// ============================================================================
// Module   : cla4_slice
// Purpose  : Combinational 4-bit carry-lookahead adder slice. Exposes the
//            carry into the MSB (c3) alongside the carry out so the caller
//            can derive signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module cla4_slice (
   input  logic [3:0] p,
   input  logic [3:0] q,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       c3,
   output logic       cout
);

   logic [3:0] w_g;   // carry generate per bit
   logic [3:0] w_t;   // carry propagate per bit
   logic [3:0] w_c;   // carry into each bit

   // Per-bit generate/propagate terms.
   for (genvar i = 0; i < 4; i++) begin : g_pg
      assign w_g[i] = p[i] & q[i];
      assign w_t[i] = p[i] ^ q[i];
   end

   // Flattened lookahead carries: every carry is a two-level function of g/t/cin.
   always_comb begin
      w_c[0] = cin;
      w_c[1] = w_g[0] | (w_t[0] & cin);
      w_c[2] = w_g[1] | (w_t[1] & w_g[0]) | (w_t[1] & w_t[0] & cin);
      w_c[3] = w_g[2] | (w_t[2] & w_g[1]) | (w_t[2] & w_t[1] & w_g[0])
             | (w_t[2] & w_t[1] & w_t[0] & cin);
      cout   = w_g[3] | (w_t[3] & w_g[2]) | (w_t[3] & w_t[2] & w_g[1])
             | (w_t[3] & w_t[2] & w_t[1] & w_g[0])
             | (w_t[3] & w_t[2] & w_t[1] & w_t[0] & cin);
      c3     = w_c[3];
      sum    = w_t ^ w_c;
   end

endmodule : cla4_slice
`default_nettype wire

// File: rtl/cla_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_ctrl
// Purpose  : Nibble-serial adder: accepts a, b, cin via a valid/ready
//            handshake, adds one nibble per clock through a single 4-bit CLA
//            slice (LSB first) and holds sum/cout until the consumer takes it.
// Options  : CLA_SEQ_OVF_EN - adds the registered signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module cla_seq_ctrl
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef CLA_SEQ_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_k;        // index of the nibble being processed
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_carry;    // carry between consecutive nibbles
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;

   logic               w_accept;
   logic               w_last;
   logic [WIDTH-1:0]   w_a_shift;
   logic [WIDTH-1:0]   w_b_shift;
   logic [NIB_W-1:0]   w_slice_sum;
   logic               w_c3;
   logic               w_c4;

   assign w_accept  = start_valid && (r_state == IDLE);
   assign w_last    = (r_k == CNT_W'(NIB - 1));
   // Shift the latched operands so the active nibble sits at the bottom.
   assign w_a_shift = r_a >> (int'(r_k) * NIB_W);
   assign w_b_shift = r_b >> (int'(r_k) * NIB_W);

   cla4_slice u_slice (
      .p    (w_a_shift[NIB_W-1:0]),
      .q    (w_b_shift[NIB_W-1:0]),
      .cin  (r_carry),
      .sum  (w_slice_sum),
      .c3   (w_c3),
      .cout (w_c4)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state: a result is only released back to IDLE, never straight into RUN.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept)  w_next = RUN;
         RUN:     if (w_last)    w_next = DONE;
         DONE:    if (res_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state.
   always_comb begin
      start_ready = (r_state == IDLE);
      res_valid   = (r_state == DONE);
      busy        = (r_state == RUN) || (r_state == DONE);
   end

   // Datapath: operand capture on accept, one slice step per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k     <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_carry <= cin;
         r_k     <= '0;
      end else if (r_state == RUN) begin
         for (int i = 0; i < NIB; i++) begin
            if (r_k == CNT_W'(i)) r_sum[i*NIB_W +: NIB_W] <= w_slice_sum;
         end
         r_carry <= w_c4;
         if (w_last) begin
            r_cout <= w_c4;
            r_k    <= '0;
         end else begin
            r_k    <= r_k + CNT_W'(1);
         end
      end
   end

`ifdef CLA_SEQ_OVF_EN
   logic r_ovf;

   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         r_ovf <= 1'b0;
      else if (r_state == RUN && w_last)  r_ovf <= w_c3 ^ w_c4;
   end

   assign ovf = r_ovf;
`endif

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule : cla_seq_ctrl
`default_nettype wire

// File: tb/tb_cla_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_seq_ctrl
// Purpose  : Self-checking bench for cla_seq_ctrl: directed vectors, random
//            operands against an arithmetic model, hold/handshake behaviour
//            and asynchronous reset during an operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_seq_ctrl;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;
   localparam int LAT   = NIB + 1;   // edges counted including the accepting edge

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef CLA_SEQ_OVF_EN
   logic             ovf;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cla_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .cin         (cin),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .sum         (sum),
      .cout        (cout),
      .busy        (busy)
`ifdef CLA_SEQ_OVF_EN
      ,
      .ovf         (ovf)
`endif
   );

   function automatic logic read_ovf();
`ifdef CLA_SEQ_OVF_EN
      return ovf;
`else
      return 1'b0;
`endif
   endfunction

   // Reference: full-width integer addition; overflow from operand/result signs.
   function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic c);
      return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
   endfunction

   function automatic logic model_ovf(input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y,
                                      input logic c);
      logic [WIDTH:0] s;
      s = model_add(x, y, c);
      return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
   endfunction

   // Offers one operation, scrambles inputs after acceptance, optionally pokes
   // start_valid mid-run, and returns the edge count until res_valid plus the
   // observed result. Leaves the result un-consumed.
   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tc, input bit inject, output int cyc,
                         output logic [WIDTH-1:0] osum, output logic ocout,
                         output logic oovf);
      @(negedge clk);
      a = ta; b = tb_; cin = tc; start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      a = WIDTH'($urandom()); b = WIDTH'($urandom()); cin = 1'($urandom());
      cyc = 1;
      while (res_valid !== 1'b1 && cyc < LAT + 10) begin
         if (inject && cyc == 2) begin
            start_valid = 1'b1;
            a = WIDTH'($urandom()); b = WIDTH'($urandom()); cin = 1'($urandom());
         end else begin
            start_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start_valid = 1'b0;
      osum  = sum;
      ocout = cout;
      oovf  = read_ovf();
   endtask

   task automatic release_res();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (sum !== '0 || cout !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0
          || read_ovf() !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: sum=%h cout=%b res_valid=%b busy=%b ovf=%b required all 0",
                  sum, cout, res_valid, busy, read_ovf());
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (start_ready !== 1'b1 || sum !== '0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_idle: start_ready=%b sum=%h busy=%b required 1/0000/0",
                  start_ready, sum, busy);
      end
   endtask

   task automatic test_directed();
      logic [WIDTH-1:0] va   [4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF};
      logic [WIDTH-1:0] vb   [4] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001};
      logic             vc   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [WIDTH-1:0] es   [4] = '{16'h5555, 16'h0000, 16'h0000, 16'h8000};
      logic             ec   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic             eo   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int cyc; logic [WIDTH-1:0] s; logic c, o;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], vc[i], 1'b0, cyc, s, c, o);
         checks++;
         if (cyc !== LAT) begin
            failures++;
            $display("FAIL dir%0d_latency: edges=%0d required %0d", i, cyc, LAT);
         end
         checks++;
         if (s !== es[i] || c !== ec[i]) begin
            failures++;
            $display("FAIL dir%0d_result: sum=%h cout=%b required %h/%b", i, s, c, es[i], ec[i]);
         end
`ifdef CLA_SEQ_OVF_EN
         checks++;
         if (o !== eo[i]) begin
            failures++;
            $display("FAIL dir%0d_ovf: ovf=%b required %b", i, o, eo[i]);
         end
`endif
         release_res();
      end
   endtask

   task automatic test_random();
      int cyc; logic [WIDTH-1:0] s; logic c, o;
      logic [WIDTH-1:0] x, y; logic ci; logic [WIDTH:0] exp;
      for (int n = 0; n < 40; n++) begin
         x = WIDTH'($urandom()); y = WIDTH'($urandom()); ci = 1'($urandom());
         if (n % 8 == 0) y = ~x;   // force full carry-propagate chains
         exp = model_add(x, y, ci);
         run_op(x, y, ci, (n % 2) == 1, cyc, s, c, o);
         checks++;
         if (cyc !== LAT || s !== exp[WIDTH-1:0] || c !== exp[WIDTH]) begin
            failures++;
            $display("FAIL rand%0d: a=%h b=%h cin=%b got sum=%h cout=%b edges=%0d required %h/%b/%0d",
                     n, x, y, ci, s, c, cyc, exp[WIDTH-1:0], exp[WIDTH], LAT);
         end
`ifdef CLA_SEQ_OVF_EN
         checks++;
         if (o !== model_ovf(x, y, ci)) begin
            failures++;
            $display("FAIL rand%0d_ovf: ovf=%b required %b", n, o, model_ovf(x, y, ci));
         end
`endif
         release_res();
      end
   endtask

   task automatic test_hold();
      int cyc; logic [WIDTH-1:0] s; logic c, o;
      logic [WIDTH:0] exp;
      exp = model_add(16'hA5C3, 16'h3C7E, 1'b1);
      run_op(16'hA5C3, 16'h3C7E, 1'b1, 1'b0, cyc, s, c, o);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || sum !== exp[WIDTH-1:0] || cout !== exp[WIDTH]
             || read_ovf() !== o) begin
            failures++;
            $display("FAIL hold%0d: res_valid=%b sum=%h cout=%b required 1/%h/%b",
                     i, res_valid, sum, cout, exp[WIDTH-1:0], exp[WIDTH]);
         end
      end
      // Consume and offer new operands in the same cycle: must not be accepted.
      res_ready = 1'b1; start_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
      @(negedge clk);
      res_ready = 1'b0; start_valid = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL release_to_idle: res_valid=%b start_ready=%b busy=%b required 0/1/0",
                  res_valid, start_ready, busy);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (sum !== exp[WIDTH-1:0] || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_retains_sum: sum=%h busy=%b required %h/0", sum, busy, exp[WIDTH-1:0]);
      end
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      @(negedge clk);   // second RUN cycle, low nibble already written
      checks++;
      if (busy !== 1'b1 || sum[3:0] !== 4'h3) begin
         failures++;
         $display("FAIL run_progress: busy=%b sum_lo=%h required 1/3", busy, sum[3:0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (sum !== '0 || cout !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0
          || read_ovf() !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: sum=%h cout=%b res_valid=%b busy=%b required all 0",
                  sum, cout, res_valid, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 2 * LAT; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen || start_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_no_result: activity_seen=%b start_ready=%b required 0/1",
                  seen, start_ready);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_hold();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_cla_seq_ctrl
`default_nettype wire
